// File: rtl/sweep_gen.sv
// Ramp generator: triangle / saw-up / saw-down between signed live bounds, optional finite cycle count.
// Latency: 2 clk from on_in rising to first sample on signal_out; outputs are registered one clk behind the accumulator.
// Backpressure: none; free-running while on_in=1 (optionally frozen by hold_in when SWEEP_HOLD_EN is defined).
//
// Ports:
//   clk_in, rst_n_in (sync, active-low)  clock / reset
//   on_in                  run enable; low stops and clears
//   mode_in                00 triangle, 01 saw-up, 10 saw-down, 11 triangle
//   minval_in, maxval_in   signed integer bounds (IN_W)
//   stepsize_in            unsigned step per clock, FRAC_W fractional bits
//   n_cycles_in            cycles before stopping; 0 = continuous
//   hold_in                only with SWEEP_HOLD_EN: freeze the running sweep
//   signal_out             signed ramp, top OUT_W bits of {int,frac}
//   dir_out                1 while descending
//   cycle_pulse_out        one-clk pulse per completed cycle, aligned with the bound on signal_out
//   done_out               high once n_cycles_in cycles have completed
// Optional feature macro: SWEEP_HOLD_EN
module sweep_gen #(
    parameter int IN_W   = 16,
    parameter int FRAC_W = 16,
    parameter int OUT_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               on_in,
`ifdef SWEEP_HOLD_EN
    input  logic               hold_in,
`endif
    input  logic [1:0]         mode_in,
    input  logic [IN_W-1:0]    minval_in,
    input  logic [IN_W-1:0]    maxval_in,
    input  logic [31:0]        stepsize_in,
    input  logic [CNT_W-1:0]   n_cycles_in,
    output logic [OUT_W-1:0]   signal_out,
    output logic               dir_out,
    output logic               cycle_pulse_out,
    output logic               done_out
);

    // Two guard bits above the integer part keep bound +/- step from wrapping.
    localparam int ACC_W = IN_W + FRAC_W + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_DOWN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] M_SAWUP = 2'b01;
    localparam logic [1:0] M_SAWDN = 2'b10;

    logic signed [ACC_W-1:0] r_acc;
    logic [1:0]              r_state;
    logic [1:0]              r_mode;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_evt;
    logic [OUT_W-1:0]        r_sig;
    logic                    r_dir;
    logic                    r_pulse;
    logic                    r_done;

    logic signed [ACC_W-1:0] w_min;
    logic signed [ACC_W-1:0] w_max;
    logic signed [ACC_W-1:0] w_step;
    logic signed [ACC_W-1:0] w_nxt_up;
    logic signed [ACC_W-1:0] w_nxt_dn;
    logic                    w_bad_bounds;
    logic                    w_hold;
    logic [CNT_W-1:0]        w_cnt_inc;

    logic signed [ACC_W-1:0] w_acc_d;
    logic [1:0]              w_state_d;
    logic [1:0]              w_mode_d;
    logic                    w_evt;

`ifdef SWEEP_HOLD_EN
    assign w_hold = hold_in;
`else
    assign w_hold = 1'b0;
`endif

    assign w_min        = {{2{minval_in[IN_W-1]}}, minval_in, {FRAC_W{1'b0}}};
    assign w_max        = {{2{maxval_in[IN_W-1]}}, maxval_in, {FRAC_W{1'b0}}};
    assign w_step       = ACC_W'(stepsize_in);
    assign w_nxt_up     = r_acc + w_step;
    assign w_nxt_dn     = r_acc - w_step;
    assign w_bad_bounds = $signed(minval_in) > $signed(maxval_in);
    assign w_cnt_inc    = r_cnt + 1'b1;

    // Next-state logic. Turns are decided on the candidate next value so the
    // accumulator never sits one step past a bound. Stop/clear on on_in=0 is
    // applied in the register block, above everything here.
    always_comb begin
        w_acc_d   = r_acc;
        w_state_d = r_state;
        w_mode_d  = r_mode;
        w_evt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_mode_d = mode_in;
                if (mode_in == M_SAWDN) begin
                    w_acc_d   = w_max;
                    w_state_d = S_DOWN;
                end else begin
                    w_acc_d   = w_min;
                    w_state_d = S_UP;
                end
            end
            S_UP, S_DOWN: begin
                if (!w_hold) begin
                    if (w_bad_bounds) begin
                        // Inverted window: pin to min, report ascending, never cycle.
                        w_acc_d   = w_min;
                        w_state_d = S_UP;
                    end else if (w_step != '0) begin
                        if (r_state == S_UP) begin
                            if (w_nxt_up > w_max) begin
                                if (r_mode == M_SAWUP) begin
                                    w_acc_d = w_min;
                                    w_evt   = 1'b1;
                                end else begin
                                    w_acc_d   = w_max;
                                    w_state_d = S_DOWN;
                                end
                            end else begin
                                w_acc_d = w_nxt_up;
                            end
                        end else begin
                            if (w_nxt_dn < w_min) begin
                                if (r_mode == M_SAWDN) begin
                                    w_acc_d = w_max;
                                end else begin
                                    w_acc_d   = w_min;
                                    w_state_d = S_UP;
                                end
                                w_evt = 1'b1;
                            end else begin
                                w_acc_d = w_nxt_dn;
                            end
                        end
                        // Final cycle: keep the bound just loaded and stop there.
                        if (w_evt && (n_cycles_in != '0) && (w_cnt_inc == n_cycles_in)) begin
                            w_state_d = S_DONE;
                        end
                    end
                end
            end
            default: begin
                // S_DONE: everything frozen until on_in drops.
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_acc   <= '0;
            r_state <= S_IDLE;
            r_mode  <= 2'b00;
            r_cnt   <= '0;
            r_evt   <= 1'b0;
            r_sig   <= '0;
            r_dir   <= 1'b0;
            r_pulse <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // Output stage lags the accumulator by one clock; pulse and done are
            // delayed the same amount so they line up with the value shown.
            r_sig   <= r_acc[IN_W+FRAC_W-1 -: OUT_W];
            r_dir   <= (r_state == S_DOWN);
            r_done  <= (r_state == S_DONE);
            r_pulse <= r_evt;
            if (!on_in) begin
                r_acc   <= '0;
                r_cnt   <= '0;
                r_state <= S_IDLE;
                r_evt   <= 1'b0;
            end else begin
                r_acc   <= w_acc_d;
                r_state <= w_state_d;
                r_mode  <= w_mode_d;
                r_evt   <= w_evt;
                if (w_evt && !(&r_cnt)) begin
                    r_cnt <= w_cnt_inc;
                end
            end
        end
    end

    assign signal_out      = r_sig;
    assign dir_out         = r_dir;
    assign cycle_pulse_out = r_pulse;
    assign done_out        = r_done;

endmodule

// File: tb/tb_sweep_gen.sv
// Directed bench for sweep_gen: reset, triangle, saw-up, saw-down, finite cycles,
// on_in drop, inverted bounds, mid-run reset and (when built with SWEEP_HOLD_EN) hold.
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
module tb_sweep_gen;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        on_in;
`ifdef SWEEP_HOLD_EN
    logic        hold_in;
`endif
    logic [1:0]  mode_in;
    logic [15:0] minval_in;
    logic [15:0] maxval_in;
    logic [31:0] stepsize_in;
    logic [15:0] n_cycles_in;
    logic [15:0] signal_out;
    logic        dir_out;
    logic        cycle_pulse_out;
    logic        done_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    sweep_gen #(.IN_W(16), .FRAC_W(16), .OUT_W(16), .CNT_W(16)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .on_in           (on_in),
`ifdef SWEEP_HOLD_EN
        .hold_in         (hold_in),
`endif
        .mode_in         (mode_in),
        .minval_in       (minval_in),
        .maxval_in       (maxval_in),
        .stepsize_in     (stepsize_in),
        .n_cycles_in     (n_cycles_in),
        .signal_out      (signal_out),
        .dir_out         (dir_out),
        .cycle_pulse_out (cycle_pulse_out),
        .done_out        (done_out)
    );

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    // Stop, load new settings, raise on_in and let the load edge pass.
    // After this, each tick shows the next accumulator value, starting with the loaded bound.
    task automatic start(input logic [1:0] m, input int mn, input int mx,
                         input logic [31:0] st, input logic [15:0] n);
        on_in = 1'b0;
        tick;
        tick;
        mode_in     = m;
        minval_in   = 16'(mn);
        maxval_in   = 16'(mx);
        stepsize_in = st;
        n_cycles_in = n;
        on_in       = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        rst_n_in = 1'b0;
        tick;
        tick;
        checks++; if (signal_out !== 16'd0) begin errors++; $display("FAIL reset_out got %0d exp 0", signal_out); end
        checks++; if (dir_out !== 1'b0) begin errors++; $display("FAIL reset_dir got %b exp 0", dir_out); end
        checks++; if (cycle_pulse_out !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b exp 0", cycle_pulse_out); end
        checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_out); end
        rst_n_in = 1'b1;
    endtask

    // min=-4 max=4 step=1.0. Each bound is reached by equality, then re-loaded on the turn.
    task automatic test_triangle;
        int vals [19] = '{-4,-3,-2,-1,0,1,2,3,4,4,3,2,1,0,-1,-2,-3,-4,-4};
        logic signed [15:0] e;
        logic ep, ed;
        int j;
        start(2'b00, -4, 4, 32'h0001_0000, 16'd0);
        for (int i = 0; i < 37; i++) begin
            tick;
            j  = (i < 19) ? i : ((i - 1) % 18) + 1;
            e  = 16'(vals[j]);
            ep = (j == 18);
            ed = (j >= 9) && (j <= 17);
            checks++; if (signal_out !== e) begin errors++; $display("FAIL tri_out[%0d] got %0d exp %0d", i, $signed(signal_out), e); end
            checks++; if (cycle_pulse_out !== ep) begin errors++; $display("FAIL tri_pulse[%0d] got %b exp %b", i, cycle_pulse_out, ep); end
            checks++; if (dir_out !== ed) begin errors++; $display("FAIL tri_dir[%0d] got %b exp %b", i, dir_out, ed); end
        end
    endtask

    // min=0 max=3 step=1.5: acc 0,1.5,3, then 4.5>3 wraps to 0.
    task automatic test_sawup;
        int vals [7] = '{0,1,3,0,1,3,0};
        logic signed [15:0] e;
        logic ep;
        start(2'b01, 0, 3, 32'h0001_8000, 16'd0);
        for (int i = 0; i < 7; i++) begin
            tick;
            e  = 16'(vals[i]);
            ep = (i == 3) || (i == 6);
            checks++; if (signal_out !== e) begin errors++; $display("FAIL saw_up_out[%0d] got %0d exp %0d", i, $signed(signal_out), e); end
            checks++; if (cycle_pulse_out !== ep) begin errors++; $display("FAIL saw_up_pulse[%0d] got %b exp %b", i, cycle_pulse_out, ep); end
            checks++; if (dir_out !== 1'b0) begin errors++; $display("FAIL saw_up_dir[%0d] got %b exp 0", i, dir_out); end
        end
    endtask

    task automatic test_sawdown;
        int vals [9] = '{3,2,1,0,3,2,1,0,3};
        logic signed [15:0] e;
        logic ep;
        start(2'b10, 0, 3, 32'h0001_0000, 16'd0);
        for (int i = 0; i < 9; i++) begin
            tick;
            e  = 16'(vals[i]);
            ep = (i == 4) || (i == 8);
            checks++; if (signal_out !== e) begin errors++; $display("FAIL saw_dn_out[%0d] got %0d exp %0d", i, $signed(signal_out), e); end
            checks++; if (cycle_pulse_out !== ep) begin errors++; $display("FAIL saw_dn_pulse[%0d] got %b exp %b", i, cycle_pulse_out, ep); end
            checks++; if (dir_out !== 1'b1) begin errors++; $display("FAIL saw_dn_dir[%0d] got %b exp 1", i, dir_out); end
        end
    endtask

    // min=0 max=10 step=3, two cycles, then frozen at 0 with done; on_in drop clears done.
    task automatic test_ncycles;
        int vals [17] = '{0,3,6,9,10,7,4,1,0,3,6,9,10,7,4,1,0};
        logic signed [15:0] e;
        logic ep, ed, edn;
        start(2'b00, 0, 10, 32'h0003_0000, 16'd2);
        for (int i = 0; i < 20; i++) begin
            tick;
            e   = (i < 17) ? 16'(vals[i]) : 16'sd0;
            ep  = (i == 8) || (i == 16);
            ed  = ((i >= 4) && (i <= 7)) || ((i >= 12) && (i <= 15));
            edn = (i >= 16);
            checks++; if (signal_out !== e) begin errors++; $display("FAIL ncyc_out[%0d] got %0d exp %0d", i, $signed(signal_out), e); end
            checks++; if (cycle_pulse_out !== ep) begin errors++; $display("FAIL ncyc_pulse[%0d] got %b exp %b", i, cycle_pulse_out, ep); end
            checks++; if (dir_out !== ed) begin errors++; $display("FAIL ncyc_dir[%0d] got %b exp %b", i, dir_out, ed); end
            checks++; if (done_out !== edn) begin errors++; $display("FAIL ncyc_done[%0d] got %b exp %b", i, done_out, edn); end
        end
        on_in = 1'b0;
        tick;
        tick;
        checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL ncyc_done_clear got %b exp 0", done_out); end
    endtask

    // Drop on_in when the output reads 5 (accumulator already at 6).
    task automatic test_on_drop;
        start(2'b00, 0, 10, 32'h0001_0000, 16'd0);
        for (int i = 0; i < 6; i++) tick;
        checks++; if (signal_out !== 16'd5) begin errors++; $display("FAIL drop_pre got %0d exp 5", $signed(signal_out)); end
        on_in = 1'b0;
        tick;
        checks++; if (signal_out !== 16'd6) begin errors++; $display("FAIL drop_lag got %0d exp 6", $signed(signal_out)); end
        tick;
        checks++; if (signal_out !== 16'd0) begin errors++; $display("FAIL drop_out got %0d exp 0", $signed(signal_out)); end
        checks++; if (dir_out !== 1'b0) begin errors++; $display("FAIL drop_dir got %b exp 0", dir_out); end
        checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL drop_done got %b exp 0", done_out); end
        checks++; if (cycle_pulse_out !== 1'b0) begin errors++; $display("FAIL drop_pulse got %b exp 0", cycle_pulse_out); end
    endtask

    task automatic test_min_gt_max;
        start(2'b00, 5, -5, 32'h0001_0000, 16'd0);
        for (int i = 0; i < 6; i++) begin
            tick;
            checks++; if (signal_out !== 16'd5) begin errors++; $display("FAIL inv_out[%0d] got %0d exp 5", i, $signed(signal_out)); end
            checks++; if (cycle_pulse_out !== 1'b0) begin errors++; $display("FAIL inv_pulse[%0d] got %b exp 0", i, cycle_pulse_out); end
            checks++; if (dir_out !== 1'b0) begin errors++; $display("FAIL inv_dir[%0d] got %b exp 0", i, dir_out); end
        end
    endtask

    task automatic test_reset_midrun;
        start(2'b00, -4, 4, 32'h0001_0000, 16'd0);
        for (int i = 0; i < 12; i++) tick;
        checks++; if (dir_out !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_dir got %b exp 1", dir_out); end
        rst_n_in = 1'b0;
        tick;
        tick;
        checks++; if (signal_out !== 16'd0) begin errors++; $display("FAIL rst_mid_out got %0d exp 0", $signed(signal_out)); end
        checks++; if (dir_out !== 1'b0) begin errors++; $display("FAIL rst_mid_dir got %b exp 0", dir_out); end
        checks++; if (cycle_pulse_out !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse got %b exp 0", cycle_pulse_out); end
        checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b exp 0", done_out); end
        on_in    = 1'b0;
        rst_n_in = 1'b1;
        tick;
    endtask

`ifdef SWEEP_HOLD_EN
    task automatic test_hold;
        start(2'b00, 0, 10, 32'h0001_0000, 16'd0);
        tick;
        tick;
        hold_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            checks++; if (signal_out !== 16'd2) begin errors++; $display("FAIL hold_out[%0d] got %0d exp 2", i, $signed(signal_out)); end
            checks++; if (cycle_pulse_out !== 1'b0) begin errors++; $display("FAIL hold_pulse[%0d] got %b exp 0", i, cycle_pulse_out); end
        end
        hold_in = 1'b0;
        tick;
        tick;
        checks++; if (signal_out !== 16'd3) begin errors++; $display("FAIL hold_resume got %0d exp 3", $signed(signal_out)); end
    endtask
`endif

    initial begin
        rst_n_in    = 1'b0;
        on_in       = 1'b0;
`ifdef SWEEP_HOLD_EN
        hold_in     = 1'b0;
`endif
        mode_in     = 2'b00;
        minval_in   = 16'd0;
        maxval_in   = 16'd0;
        stepsize_in = 32'd0;
        n_cycles_in = 16'd0;
        test_reset;
        test_triangle;
        test_sawup;
        test_sawdown;
        test_ncycles;
        test_on_drop;
        test_min_gt_max;
        test_reset_midrun;
`ifdef SWEEP_HOLD_EN
        test_hold;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
